// File: rtl/avr_dmem.sv
// avr_dmem: data-space SRAM for avr_cpu with 1-cycle registered reads, plus a
// req/ack debug/loader port that owns the RAM while the CPU is halted.
module avr_dmem #(
  parameter logic [15:0] RAM_BASE  = 16'h0060,
  parameter int          RAM_DEPTH = 1024
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [15:0] d_addr,
  input  logic        data_write,
  inout  wire  [7:0]  data,
  input  logic        cpu_halt,
  input  logic        dbg_req,
  input  logic        dbg_we,
  input  logic [15:0] dbg_addr,
  input  logic [7:0]  dbg_wdata,
  output logic        dbg_ack,
  output logic [7:0]  dbg_rdata,
  output logic        oob_err
);

  localparam int AW = $clog2(RAM_DEPTH);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE, WAITLO} dbg_state_e;

  // Unsigned 16-bit offset check: addresses below RAM_BASE wrap to huge offsets.
  function automatic logic in_range(input logic [15:0] a);
    return (a >= RAM_BASE) && ({16'h0000, a - RAM_BASE} < 32'(RAM_DEPTH));
  endfunction

  logic [7:0]  mem [RAM_DEPTH];

  dbg_state_e  state_q;
  logic [7:0]  rd_q;
  logic        dbg_ack_q;
  logic [7:0]  dbg_rdata_q;
  logic        oob_err_q;
  logic        dbg_we_q;
  logic [15:0] dbg_addr_q;
  logic [7:0]  dbg_wdata_q;

  logic          cpu_rd, cpu_wr, cpu_in, dbg_in, dbg_access;
  logic [AW-1:0] cpu_idx, dbg_idx;
  logic          mem_we_d;
  logic [AW-1:0] mem_idx_d;
  logic [7:0]    mem_wdata_d;

  assign cpu_rd     = !cpu_halt && !data_write;
  assign cpu_wr     = !cpu_halt && data_write;
  assign cpu_in     = in_range(d_addr);
  assign dbg_in     = in_range(dbg_addr_q);
  assign cpu_idx    = AW'(d_addr - RAM_BASE);
  assign dbg_idx    = AW'(dbg_addr_q - RAM_BASE);
  assign dbg_access = cpu_halt && (state_q == ACCESS);

  // CPU and debug writes never coincide: one needs cpu_halt=0, the other cpu_halt=1.
  assign mem_we_d    = !RST && ((cpu_wr && cpu_in) || (dbg_access && dbg_we_q && dbg_in));
  assign mem_idx_d   = cpu_halt ? dbg_idx : cpu_idx;
  assign mem_wdata_d = cpu_halt ? dbg_wdata_q : data;

  // NOTE: the RAM array has no reset; clearing it would turn the array into flops.
  always_ff @(posedge CLK) begin
    if (mem_we_d) mem[mem_idx_d] <= mem_wdata_d;
  end

  // NOTE: all state uses <= so every read of mem/state sees pre-edge values.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      rd_q        <= 8'h00;
      dbg_ack_q   <= 1'b0;
      dbg_rdata_q <= 8'h00;
      oob_err_q   <= 1'b0;
      dbg_we_q    <= 1'b0;
      dbg_addr_q  <= 16'h0000;
      dbg_wdata_q <= 8'h00;
    end else begin
      if (cpu_rd) rd_q <= cpu_in ? mem[cpu_idx] : 8'h00;
      if (cpu_wr && !cpu_in) oob_err_q <= 1'b1;

      dbg_ack_q <= 1'b0;
      if (!cpu_halt) begin
        state_q <= IDLE;
      end else begin
        case (state_q)
          IDLE: if (dbg_req) begin
            dbg_we_q    <= dbg_we;
            dbg_addr_q  <= dbg_addr;
            dbg_wdata_q <= dbg_wdata;
            state_q     <= ACCESS;
          end
          ACCESS: begin
            if (!dbg_we_q) dbg_rdata_q <= dbg_in ? mem[dbg_idx] : 8'h00;
            if (!dbg_in) oob_err_q <= 1'b1;
            dbg_ack_q <= 1'b1;
            state_q   <= DONE;
          end
          DONE:    state_q <= WAITLO;
          WAITLO:  if (!dbg_req) state_q <= IDLE;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign data      = cpu_rd ? rd_q : 8'bz;
  assign dbg_ack   = dbg_ack_q;
  assign dbg_rdata = dbg_rdata_q;
  assign oob_err   = oob_err_q;

endmodule

// File: tb/tb_avr_dmem.sv
// tb_avr_dmem: directed + randomized checks of avr_dmem against an address-keyed byte model.
module tb_avr_dmem;

  logic        CLK = 1'b0;
  logic        RST;
  logic [15:0] d_addr;
  logic        data_write;
  wire  [7:0]  data;
  logic        cpu_halt;
  logic        dbg_req;
  logic        dbg_we;
  logic [15:0] dbg_addr;
  logic [7:0]  dbg_wdata;
  logic        dbg_ack;
  logic [7:0]  dbg_rdata;
  logic        oob_err;

  logic [7:0]  tb_dq;
  logic        tb_den;
  assign data = tb_den ? tb_dq : 8'bz;

  avr_dmem dut (
    .CLK(CLK), .RST(RST), .d_addr(d_addr), .data_write(data_write), .data(data),
    .cpu_halt(cpu_halt), .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
    .dbg_wdata(dbg_wdata), .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata), .oob_err(oob_err)
  );

  always #5 CLK = ~CLK;

  int         total = 0;
  int         bad   = 0;
  logic [7:0] ref_mem [int];
  int         written[$];
  logic       exp_oob;
  logic [7:0] exp_rd;
  logic [7:0] exp_dbg;

  function automatic bit backed(input int a);
    return (a >= 'h60) && (a < 'h60 + 1024);
  endfunction

  function automatic int pick_addr();
    case ($urandom_range(0, 3))
      0:       return 'h60 + int'($urandom_range(0, 3));
      1:       return 'h45C + int'($urandom_range(0, 3));
      default: return int'($urandom_range('h60, 'h45F));
    endcase
  endfunction

  function automatic int pick_written();
    return written[$urandom_range(0, written.size() - 1)];
  endfunction

  function automatic int pick_oor();
    return $urandom_range(0, 1) ? int'($urandom_range(0, 'h5F)) : int'($urandom_range('h460, 'hFFFF));
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic model_write(input int a, input logic [7:0] d);
    if (backed(a)) begin
      if (!ref_mem.exists(a)) written.push_back(a);
      ref_mem[a] = d;
    end else begin
      exp_oob = 1'b1;
    end
  endtask

  task automatic cpu_write(input int a, input logic [7:0] d);
    d_addr = 16'(a); data_write = 1'b1; tb_den = 1'b1; tb_dq = d;
    tick();
    model_write(a, d);
  endtask

  task automatic cpu_read(input int a, input string tag);
    d_addr = 16'(a); data_write = 1'b0; tb_den = 1'b0;
    tick();
    exp_rd = backed(a) ? ref_mem[a] : 8'h00;
    check(tag, 16'(data), 16'(exp_rd));
  endtask

  // Full debug handshake; hold keeps req high extra cycles after the ack.
  task automatic dbg_xfer(input bit we, input int a, input logic [7:0] wd, input int hold);
    dbg_req = 1'b1; dbg_we = we; dbg_addr = 16'(a); dbg_wdata = wd;
    tick();
    check("dbg_ack_access", 16'(dbg_ack), 16'h0000);
    dbg_we = ~we; dbg_addr = 16'hFFFF; dbg_wdata = ~wd;
    tick();
    if (we) model_write(a, wd);
    else begin
      exp_dbg = backed(a) ? ref_mem[a] : 8'h00;
      if (!backed(a)) exp_oob = 1'b1;
    end
    check("dbg_ack_done", 16'(dbg_ack), 16'h0001);
    check("dbg_rdata", 16'(dbg_rdata), 16'(exp_dbg));
    check("dbg_oob", 16'(oob_err), 16'(exp_oob));
    check("bus_released", 16'(data), 16'h0000);
    for (int i = 0; i < hold; i++) begin
      tick();
      check("dbg_ack_held_req", 16'(dbg_ack), 16'h0000);
    end
    dbg_req = 1'b0;
    tick();
    check("dbg_ack_pulse", 16'(dbg_ack), 16'h0000);
    tick();
  endtask

  initial begin
    RST = 1'b1; d_addr = '0; data_write = 1'b0; cpu_halt = 1'b0;
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
    tb_den = 1'b0; tb_dq = '0;
    exp_oob = 1'b0; exp_rd = 8'h00; exp_dbg = 8'h00;

    tick(); tick();
    check("rst_rd", 16'(data), 16'h0000);
    check("rst_ack", 16'(dbg_ack), 16'h0000);
    check("rst_rdata", 16'(dbg_rdata), 16'h0000);
    check("rst_oob", 16'(oob_err), 16'h0000);
    RST = 1'b0;

    cpu_write('h60, 8'hA5);
    cpu_read('h60, "write_first");
    cpu_write('h420, 8'h11);
    cpu_write('h45F, 8'h12);
    cpu_write('h45E, 8'h34);
    cpu_read('h45F, "ret_top");
    cpu_read('h460, "ret_oor_zero");
    check("ret_oor_no_err", 16'(oob_err), 16'h0000);
    cpu_read('h45E, "ret_next");

    // rd_q must hold through a write cycle.
    cpu_write('h100, 8'h77);
    d_addr = 16'h0100; data_write = 1'b0; tb_den = 1'b0;
    #1;
    check("rd_hold_over_write", 16'(data), 16'(exp_rd));
    tick();
    exp_rd = ref_mem['h100];
    check("rd_after_hold", 16'(data), 16'(exp_rd));

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 1) == 1)      cpu_write(pick_addr(), 8'($urandom_range(1, 255)));
      else if ($urandom_range(0, 3) == 0) cpu_read(pick_oor(), "rand_rd_oor");
      else                                cpu_read(pick_written(), "rand_rd");
    end
    check("oob_quiet", 16'(oob_err), 16'h0000);

    cpu_write('h20, 8'hEE);
    check("oob_set", 16'(oob_err), 16'h0001);
    cpu_read('h420, "no_alias");
    cpu_read('h30, "io_read_zero");
    check("oob_sticky", 16'(oob_err), 16'h0001);

    RST = 1'b1;
    tick();
    exp_oob = 1'b0; exp_rd = 8'h00;
    check("rst_clears_oob", 16'(oob_err), 16'h0000);
    RST = 1'b0;
    cpu_read('h45F, "ram_kept_after_rst");

    // Halted: TB drives 0 on the bus, so any DUT drive of rd_q corrupts it.
    cpu_halt = 1'b1; data_write = 1'b1; tb_den = 1'b1; tb_dq = 8'h99; d_addr = 16'h0060;
    tick(); tick();
    data_write = 1'b0; tb_dq = 8'h00;
    #1;
    check("bus_z_halt", 16'(data), 16'h0000);

    dbg_xfer(1'b1, 'h100, 8'h5A, 0);
    dbg_xfer(1'b0, 'h100, 8'h00, 0);
    dbg_xfer(1'b0, 'h60, 8'h00, 3);
    for (int i = 0; i < 12; i++) begin
      if ($urandom_range(0, 1) == 1) dbg_xfer(1'b1, pick_addr(), 8'($urandom_range(1, 255)), 0);
      else                           dbg_xfer(1'b0, pick_written(), 8'h00, 0);
    end
    dbg_xfer(1'b0, 'h10, 8'h00, 0);

    // Abort a debug read in ACCESS by dropping cpu_halt.
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 16'h0060;
    tick();
    cpu_halt = 1'b0; dbg_req = 1'b0; data_write = 1'b0; tb_den = 1'b0; d_addr = 16'h045F;
    #1;
    check("rd_frozen_in_halt", 16'(data), 16'(exp_rd));
    tick();
    exp_rd = ref_mem['h45F];
    check("abort_no_ack", 16'(dbg_ack), 16'h0000);
    check("abort_rdata_kept", 16'(dbg_rdata), 16'(exp_dbg));
    check("rd_after_halt", 16'(data), 16'(exp_rd));
    cpu_halt = 1'b1; tb_den = 1'b1; tb_dq = 8'h00;
    dbg_xfer(1'b0, 'h100, 8'h00, 0);

    // Reset while a debug write sits in ACCESS.
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 16'h0100; dbg_wdata = 8'hEE;
    tick();
    RST = 1'b1;
    tick();
    check("rst_mid_no_ack", 16'(dbg_ack), 16'h0000);
    RST = 1'b0; dbg_req = 1'b0;
    exp_oob = 1'b0; exp_rd = 8'h00; exp_dbg = 8'h00;
    tick();
    check("rst_mid_ack_low", 16'(dbg_ack), 16'h0000);
    check("rst_mid_oob", 16'(oob_err), 16'h0000);
    dbg_xfer(1'b0, 'h100, 8'h00, 0);

    cpu_halt = 1'b0;
    cpu_read('h100, "cpu_sees_dbg_data");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
